// File: rtl/ecall_pkg.sv
// Shared constants and state encoding for the ecall service sequencer.
package ecall_pkg;

  localparam logic [31:0] ECALL_INSN = 32'h00000073;

  localparam int SVC_PRINT_DEF = 1;
  localparam int SVC_READ_DEF  = 5;
  localparam int SVC_EXIT_DEF  = 10;

  localparam logic [4:0] X10 = 5'd10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_IN  = 3'd1,
    WAIT_OUT = 3'd2,
    WB       = 3'd3,
    DONE     = 3'd4,
    HALT     = 3'd5
  } ecall_state_e;

endpackage

// File: rtl/rise_detect.sv
// Registers a level and reports its rising edge for one cycle.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_d, in_q;

  always_comb begin
    in_d = in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/ecall_io_ctrl.sv
// Sequences ecall read/print/exit services, stalling the core while the board user acts.
// Handshake: a service is accepted in the detection cycle (stall=1); confirm's rising edge completes it.
module ecall_io_ctrl
  import ecall_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SW_W      = 16,
  parameter bit SW_SIGNED = 1'b1,
  parameter int SVC_PRINT = SVC_PRINT_DEF,
  parameter int SVC_READ  = SVC_READ_DEF,
  parameter int SVC_EXIT  = SVC_EXIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              inst_valid,
  input  logic [DATA_W-1:0] a7,
  input  logic [DATA_W-1:0] a0,
  input  logic [SW_W-1:0]   sw,
  input  logic              confirm,
  output logic              stall,
  output logic              io_regWrite,
  output logic [DATA_W-1:0] io_wdata,
  output logic [4:0]        io_rd,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              halted,
  output ecall_state_e      dbg_state
);

  ecall_state_e      state_d, state_q;
  logic [DATA_W-1:0] io_wdata_d, io_wdata_q;
  logic [DATA_W-1:0] disp_data_d, disp_data_q;
  logic              rise;
  logic              ecall_hit;
  logic              is_read, is_print, is_exit;
  logic [DATA_W-1:0] sw_ext;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .in    (confirm),
    .rise  (rise)
  );

  assign ecall_hit = inst_valid & (instruction == ECALL_INSN);
  assign is_read   = (a7 == DATA_W'(SVC_READ));
  assign is_print  = (a7 == DATA_W'(SVC_PRINT));
  assign is_exit   = (a7 == DATA_W'(SVC_EXIT));
  assign sw_ext    = {{(DATA_W-SW_W){SW_SIGNED & sw[SW_W-1]}}, sw};

  always_comb begin
    state_d     = state_q;
    io_wdata_d  = io_wdata_q;
    disp_data_d = disp_data_q;
    stall       = 1'b0;
    io_regWrite = 1'b0;
    disp_valid  = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ecall_hit) begin
          if (is_read) begin
            stall   = 1'b1;
            state_d = WAIT_IN;
          end else if (is_print) begin
            stall       = 1'b1;
            disp_data_d = a0;
            state_d     = WAIT_OUT;
          end else if (is_exit) begin
            stall   = 1'b1;
            state_d = HALT;
          end
        end
      end
      WAIT_IN: begin
        stall = 1'b1;
        if (rise) begin
          io_wdata_d = sw_ext;
          state_d    = WB;
        end
      end
      WAIT_OUT: begin
        stall      = 1'b1;
        disp_valid = 1'b1;
        if (rise) state_d = DONE;
      end
      // The ecall retires here; no re-decode, so it cannot retrigger.
      WB: begin
        io_regWrite = 1'b1;
        state_d     = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      io_wdata_q  <= '0;
      disp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      io_wdata_q  <= io_wdata_d;
      disp_data_q <= disp_data_d;
    end
  end

  assign io_wdata  = io_wdata_q;
  assign disp_data = disp_data_q;
  assign io_rd     = X10;
  assign dbg_state = state_q;

endmodule
